// File: rtl/pkt_send_arbiter_pkg.sv
// Shared definitions for the packet send arbiter: beat tags, bus widths,
// FSM state encoding and a small tag-extraction helper.
package pkt_pkg;

  localparam int DATA_W = 134;
  localparam int META_W = 168;

  // Tag lives in the two MSBs of every beat.
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic [1:0] beat_tag(input logic [DATA_W-1:0] beat);
    return beat[DATA_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pkt_send_arbiter_if.sv
// Bundle of the requester-side and downstream-side signals of the arbiter.
// The arbiter connects through the slave modport; the traffic source and
// sink (or a testbench) use the master modport.
interface pkt_send_arbiter_if #(
  parameter int N_PORT = 4,
  parameter int CNT_W  = 16
);
  import pkt_pkg::*;

  logic [N_PORT-1:0]        i_req_valid;
  logic [N_PORT*DATA_W-1:0] i_req_data;
  logic [N_PORT*META_W-1:0] i_req_meta;
  logic [N_PORT-1:0]        o_req_ready;
  logic                     i_alf;
  logic                     o_data_valid;
  logic [DATA_W-1:0]        o_data;
  logic                     o_meta_valid;
  logic [META_W-1:0]        o_meta;
  logic [N_PORT*CNT_W-1:0]  o_pkt_cnt;
  logic [CNT_W-1:0]         o_err_cnt;

  modport master (
    output i_req_valid, i_req_data, i_req_meta, i_alf,
    input  o_req_ready, o_data_valid, o_data, o_meta_valid, o_meta,
           o_pkt_cnt, o_err_cnt
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_meta, i_alf,
    output o_req_ready, o_data_valid, o_data, o_meta_valid, o_meta,
           o_pkt_cnt, o_err_cnt
  );

endinterface

// File: rtl/pkt_send_arbiter_rr_pick.sv
// Combinational round-robin search: returns the first set bit of i_req at
// or above i_ptr, wrapping from N_PORT-1 back to 0.
module rr_pick #(
  parameter int N_PORT = 4,
  parameter int PTR_W  = 2
) (
  input  logic [N_PORT-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic              o_any,
  output logic [PTR_W-1:0]  o_idx
);

  logic [PTR_W:0] w_pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    o_any = 1'b0;
    o_idx = '0;
    w_pos = '0;
    for (int i = N_PORT - 1; i >= 0; i--) begin
      w_pos = {1'b0, i_ptr} + (PTR_W + 1)'(i);
      if (w_pos >= (PTR_W + 1)'(N_PORT)) begin
        w_pos = w_pos - (PTR_W + 1)'(N_PORT);
      end
      if (i_req[w_pos[PTR_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pkt_send_arbiter.sv
// Packet-atomic round-robin arbiter. Malformed packets (front beat not a
// head) win arbitration first and are flushed; well-formed packets are only
// granted while the downstream is not almost-full, then run to their tail.
module pkt_send_arbiter
  import pkt_pkg::*;
#(
  parameter int N_PORT = 4,
  parameter int PTR_W  = $clog2(N_PORT),
  parameter int CNT_W  = 16
) (
  input logic               i_sys_clk,
  input logic               i_rst,
  pkt_send_arbiter_if.slave io_bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_grant;
  logic [PTR_W-1:0]   w_grant_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_rr_nxt;
  logic               r_sop;

  logic [DATA_W-1:0]  w_data [N_PORT];
  logic [META_W-1:0]  w_meta [N_PORT];
  logic [N_PORT-1:0]  w_bad;
  logic [N_PORT-1:0]  w_head;
  logic [N_PORT-1:0]  w_cand;
  logic [N_PORT-1:0]  w_ready;
  logic               w_any_bad;
  logic               w_pick_any;
  logic [PTR_W-1:0]   w_pick_idx;

  logic [DATA_W-1:0]  w_beat;
  logic               w_acc;
  logic               w_tail_acc;
  logic               w_fwd;
  logic               w_fwd_head;

  logic               r_data_valid;
  logic [DATA_W-1:0]  r_data;
  logic               r_meta_valid;
  logic [META_W-1:0]  r_meta;
  logic [CNT_W-1:0]   r_pkt_cnt [N_PORT];
  logic [CNT_W-1:0]   r_err_cnt;

  // Per-port unpacking and candidate classification.
  for (genvar g = 0; g < N_PORT; g++) begin : g_port
    assign w_data[g] = io_bus.i_req_data[g*DATA_W +: DATA_W];
    assign w_meta[g] = io_bus.i_req_meta[g*META_W +: META_W];
    assign w_bad[g]  = io_bus.i_req_valid[g] && (beat_tag(w_data[g]) != TAG_HEAD);
    assign w_head[g] = io_bus.i_req_valid[g] && (beat_tag(w_data[g]) == TAG_HEAD)
                       && !io_bus.i_alf;
    assign io_bus.o_pkt_cnt[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
  end

  // Malformed fronts preempt heads; heads are eligible only below almost-full.
  assign w_any_bad = |w_bad;
  assign w_cand    = w_any_bad ? w_bad : w_head;

  rr_pick #(
    .N_PORT (N_PORT),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .i_req (w_cand),
    .i_ptr (r_rr_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  assign w_beat     = w_data[r_grant];
  assign w_acc      = (r_state != IDLE) && io_bus.i_req_valid[r_grant];
  assign w_tail_acc = w_acc && (beat_tag(w_beat) == TAG_TAIL);
  assign w_fwd      = w_acc && (r_state == XFER);
  assign w_fwd_head = w_fwd && r_sop;

  // Ready depends on state and grant only, never on the requester's valid.
  always_comb begin
    w_ready = '0;
    if (r_state != IDLE) begin
      w_ready[r_grant] = 1'b1;
    end
  end

  // Next-state, next-grant and round-robin pointer update.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = w_any_bad ? DROP : XFER;
        end
      end
      XFER, DROP: begin
        if (w_tail_acc) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = (r_grant == PTR_W'(N_PORT - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, grant, pointer and start-of-packet flag.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_sop    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_sop    <= (r_state == IDLE) ? w_pick_any : (r_sop && !w_acc);
    end
  end

  // Registered output beat; meta is captured only with the packet's first beat.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_meta_valid <= 1'b0;
      r_meta       <= '0;
    end else begin
      r_data_valid <= w_fwd;
      r_meta_valid <= w_fwd_head;
      if (w_fwd) begin
        r_data <= w_beat;
      end
      if (w_fwd_head) begin
        r_meta <= w_meta[r_grant];
      end
    end
  end

  // Wrapping statistics: forwarded packets per port, dropped packets overall.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the counter array is a handful of flops, so it is cleared like
      // any other register; it is not a RAM that would lose its inference.
      for (int k = 0; k < N_PORT; k++) begin
        r_pkt_cnt[k] <= '0;
      end
      r_err_cnt <= '0;
    end else if (w_tail_acc) begin
      if (r_state == XFER) begin
        r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 1'b1;
      end else begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign io_bus.o_req_ready  = w_ready;
  assign io_bus.o_data_valid = r_data_valid;
  assign io_bus.o_data       = r_data;
  assign io_bus.o_meta_valid = r_meta_valid;
  assign io_bus.o_meta       = r_meta;
  assign io_bus.o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_pkt_send_arbiter.sv
// Self-checking bench for pkt_send_arbiter: directed scenarios plus a
// randomized run, compared against a packet-level reference model.
`timescale 1ns/1ps
module tb_pkt_send_arbiter;
  import pkt_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [META_W-1:0] meta;
    logic              first;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_send_arbiter_if #(.N_PORT(N), .CNT_W(CW)) bus ();

  pkt_send_arbiter #(.N_PORT(N), .PTR_W(2), .CNT_W(CW)) dut (
    .i_sys_clk (clk),
    .i_rst     (rst),
    .io_bus    (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  beat_t pq [N][$];
  int    stall [N];
  bit    bubble_en;
  bit    mid_head_en;

  logic [DATA_W-1:0] out_q [$];
  int                out_cyc [$];
  logic [META_W-1:0] mout_q [$];
  int                mout_idx [$];

  logic [DATA_W-1:0] exp_q [$];
  logic [META_W-1:0] mexp_q [$];
  int                mexp_idx [$];
  int                exp_cnt [N];
  int                exp_err;
  int                m_rr;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_beat(input int port, input logic [1:0] tag);
    logic [DATA_W-1:0] d;
    d[31:0]    = $urandom;
    d[63:32]   = $urandom;
    d[95:64]   = $urandom;
    d[127:96]  = $urandom;
    d[133:128] = 6'($urandom);
    d[133:132] = tag;
    d[131:129] = 3'(port);
    return d;
  endfunction

  function automatic logic [META_W-1:0] rand_meta();
    logic [META_W-1:0] m;
    m[31:0]    = $urandom;
    m[63:32]   = $urandom;
    m[95:64]   = $urandom;
    m[127:96]  = $urandom;
    m[159:128] = $urandom;
    m[167:160] = 8'($urandom);
    return m;
  endfunction

  task automatic add_pkt(input int port, input int len, input bit bad,
                         input logic [META_W-1:0] meta);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      logic [1:0] t;
      if (i == 0)                                           t = bad ? TAG_BODY : TAG_HEAD;
      else if (i == len - 1)                                t = TAG_TAIL;
      else if (mid_head_en && !bad && $urandom_range(7) == 0) t = TAG_HEAD;
      else                                                  t = TAG_BODY;
      b.data  = mk_beat(port, t);
      b.meta  = meta;
      b.first = (i == 0);
      pq[port].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (pq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Present each port's front beat; packet fronts are never withheld.
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      logic v;
      v = 1'b0;
      if (pq[k].size() != 0) begin
        if (pq[k][0].first)    v = 1'b1;
        else if (stall[k] > 0) stall[k]--;
        else if (bubble_en)    v = ($urandom_range(3) != 0);
        else                   v = 1'b1;
        bus.i_req_data[k*DATA_W +: DATA_W] = pq[k][0].data;
        bus.i_req_meta[k*META_W +: META_W] = pq[k][0].meta;
      end
      bus.i_req_valid[k] = v;
    end
  endtask

  // One clock: sample outputs and handshakes mid-cycle, then advance sources.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    if (bus.o_data_valid) begin
      out_q.push_back(bus.o_data);
      out_cyc.push_back(cyc);
    end
    if (bus.o_meta_valid) begin
      mout_q.push_back(bus.o_meta);
      mout_idx.push_back(out_q.size() - 1);
    end
    acc = bus.i_req_valid & bus.o_req_ready;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) void'(pq[k].pop_front());
    drive();
  endtask

  task automatic run_drain(input string tag, input int limit);
    int n;
    bit done;
    n = 0;
    while (n < limit && !all_empty()) begin
      step();
      n++;
    end
    done = all_empty();
    check({tag, "_done"}, 256'(done), 256'(1));
    repeat (4) step();
  endtask

  // Packet-level reference: every loaded port competes from the start.
  // Malformed fronts win first; otherwise first non-empty port from rr.
  task automatic model_run();
    beat_t mq [N][$];
    for (int k = 0; k < N; k++) mq[k] = pq[k];
    while (1) begin
      int win;
      bit any_bad;
      bit bad;
      bit tail;
      win = -1;
      any_bad = 1'b0;
      for (int k = 0; k < N; k++)
        if (mq[k].size() != 0 && mq[k][0].data[DATA_W-1 -: 2] != TAG_HEAD) any_bad = 1'b1;
      for (int i = 0; i < N; i++) begin
        int p;
        p = (m_rr + i) % N;
        if (win < 0 && mq[p].size() != 0 &&
            (!any_bad || mq[p][0].data[DATA_W-1 -: 2] != TAG_HEAD)) win = p;
      end
      if (win < 0) break;
      bad = (mq[win][0].data[DATA_W-1 -: 2] != TAG_HEAD);
      if (!bad) begin
        mexp_idx.push_back(exp_q.size());
        mexp_q.push_back(mq[win][0].meta);
      end
      tail = 1'b0;
      while (!tail && mq[win].size() != 0) begin
        beat_t b;
        b = mq[win].pop_front();
        tail = (b.data[DATA_W-1 -: 2] == TAG_TAIL);
        if (!bad) exp_q.push_back(b.data);
      end
      if (bad) exp_err++;
      else     exp_cnt[win]++;
      m_rr = (win + 1) % N;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) exp_cnt[k] = 0;
    exp_err = 0;
    m_rr    = 0;
  endtask

  task automatic clear_logs();
    out_q.delete(); out_cyc.delete(); mout_q.delete(); mout_idx.delete();
    exp_q.delete(); mexp_q.delete(); mexp_idx.delete();
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_nbeats"}, 256'(out_q.size()), 256'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), 256'(out_q[i]), 256'(exp_q[i]));
    check({tag, "_nmeta"}, 256'(mout_q.size()), 256'(mexp_q.size()));
    n = (mout_q.size() < mexp_q.size()) ? mout_q.size() : mexp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_meta%0d", tag, i), 256'(mout_q[i]), 256'(mexp_q[i]));
      check($sformatf("%s_metapos%0d", tag, i), 256'(mout_idx[i]), 256'(mexp_idx[i]));
    end
    check({tag, "_errcnt"}, 256'(bus.o_err_cnt), 256'(exp_err));
    for (int k = 0; k < N; k++)
      check($sformatf("%s_pktcnt%0d", tag, k), 256'(bus.o_pkt_cnt[k*CW +: CW]),
            256'(exp_cnt[k]));
    clear_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_meta  = '0;
    bus.i_alf       = 1'b0;
    bubble_en   = 1'b0;
    mid_head_en = 1'b0;
    for (int k = 0; k < N; k++) stall[k] = 0;
    model_reset();

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",     256'(bus.o_req_ready),  256'(0));
    check("rst_dvalid",    256'(bus.o_data_valid), 256'(0));
    check("rst_mvalid",    256'(bus.o_meta_valid), 256'(0));
    check("rst_data",      256'(bus.o_data),       256'(0));
    check("rst_meta",      256'(bus.o_meta),       256'(0));
    check("rst_pktcnt",    256'(bus.o_pkt_cnt),    256'(0));
    check("rst_errcnt",    256'(bus.o_err_cnt),    256'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Single 3-beat packet on port 0: beats out at +2..+4.
    add_pkt(0, 3, 1'b0, 168'hA5);
    model_run();
    c0 = cyc;
    drive();
    run_drain("A", 50);
    check("A_head_lat", 256'(out_cyc[0] - c0), 256'(2));
    check("A_tail_lat", 256'(out_cyc[2] - c0), 256'(4));
    check("A_meta_a5",  256'(mout_q[0]),        256'(168'hA5));
    compare("A");

    // All ports backlogged with two 2-beat packets; pointer resumes at 1.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) add_pkt(k, 2, 1'b0, rand_meta());
    model_run();
    drive();
    run_drain("B", 200);
    for (int i = 0; i < 2 * N; i++) begin
      logic [DATA_W-1:0] h;
      h = out_q[2*i];
      check($sformatf("B_order%0d", i), 256'(h[131:129]), 256'((1 + i) % N));
    end
    compare("B");

    // Almost-full blocks a head; released head appears 2 cycles later and
    // re-asserting almost-full mid-packet does not stall it.
    bus.i_alf = 1'b1;
    add_pkt(2, 4, 1'b0, rand_meta());
    model_run();
    drive();
    repeat (6) step();
    check("C_blocked_ready", 256'(bus.o_req_ready), 256'(0));
    check("C_blocked_out",   256'(out_q.size()),    256'(0));
    bus.i_alf = 1'b0;
    c0 = cyc;
    n = 0;
    while (out_q.size() == 0 && n < 20) begin
      step();
      n++;
    end
    bus.i_alf = 1'b1;
    run_drain("C", 50);
    bus.i_alf = 1'b0;
    check("C_head_lat", 256'(out_cyc[0] - c0), 256'(2));
    check("C_tail_lat", 256'(out_cyc[3] - c0), 256'(5));
    compare("C");

    // Malformed packet on port 1 is flushed even under almost-full;
    // port 3's waiting head is served afterwards.
    bus.i_alf = 1'b1;
    add_pkt(1, 2, 1'b1, rand_meta());
    add_pkt(3, 2, 1'b0, rand_meta());
    model_run();
    drive();
    repeat (6) step();
    check("D_err_one",  256'(bus.o_err_cnt), 256'(1));
    check("D_no_out",   256'(out_q.size()),  256'(0));
    bus.i_alf = 1'b0;
    run_drain("D", 50);
    check("D_port3", 256'(out_q[0][131:129]), 256'(3));
    compare("D");

    // Port 0 stalls 5 cycles mid-packet; port 1 waits for its tail.
    add_pkt(0, 4, 1'b0, rand_meta());
    add_pkt(1, 2, 1'b0, rand_meta());
    stall[0] = 5;
    model_run();
    drive();
    repeat (4) step();
    check("E_hold_grant", 256'(bus.o_req_ready), 256'(4'b0001));
    run_drain("E", 80);
    check("E_bubble", 256'(out_cyc[1] - out_cyc[0]), 256'(6));
    check("E_p1_after_tail", 256'(out_cyc[4] > out_cyc[3]), 256'(1));
    compare("E");

    // Reset during beat 2 of a 4-beat packet.
    add_pkt(2, 4, 1'b0, rand_meta());
    drive();
    step();
    step();
    rst = 1'b1;
    #1;
    check("F_ready",  256'(bus.o_req_ready),  256'(0));
    check("F_dvalid", 256'(bus.o_data_valid), 256'(0));
    check("F_mvalid", 256'(bus.o_meta_valid), 256'(0));
    check("F_data",   256'(bus.o_data),       256'(0));
    check("F_meta",   256'(bus.o_meta),       256'(0));
    check("F_pktcnt", 256'(bus.o_pkt_cnt),    256'(0));
    check("F_errcnt", 256'(bus.o_err_cnt),    256'(0));
    for (int k = 0; k < N; k++) pq[k].delete();
    drive();
    clear_logs();
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) add_pkt(k, 2, 1'b0, rand_meta());
    model_run();
    drive();
    run_drain("F", 100);
    check("F_first_port0", 256'(out_q[0][131:129]), 256'(0));
    compare("F");

    // Randomized traffic: lengths, malformed packets, bubbles, inner heads.
    bubble_en   = 1'b1;
    mid_head_en = 1'b1;
    for (int k = 0; k < N; k++) begin
      int npk;
      npk = $urandom_range(6, 3);
      for (int p = 0; p < npk; p++)
        add_pkt(k, $urandom_range(5, 2), ($urandom_range(5) == 0), rand_meta());
    end
    model_run();
    drive();
    run_drain("G", 2000);
    compare("G");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_send_arbiter.md
Name: pkt_send_arbiter

Overview:
- Packet-atomic round-robin arbiter sharing one 134-bit data / 168-bit meta packet stream among N requesters (e.g. DMA, DRA, conf engines) on the sys-clock side.
- Its output drives the packet input of the async pkt receive path.
- Honours the downstream almost-full flag at packet boundaries only.
- Flushes malformed packets (front beat not a head) without forwarding them.

Parameters:
- N_PORT, 4, number of requesters (2..8).
- PTR_W, 2, width of grant index/pointer; equals clog2(N_PORT).
- CNT_W, 16, width of per-port statistics counters.

Ports:
- i_sys_clk  in  1  block clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  N_PORT  per-port beat valid.
- i_req_data  in  N_PORT*134  per-port beat; port k occupies [k*134+:134]; tag [133:132]: 01 head, 11 body, 10 tail.
- i_req_meta  in  N_PORT*168  per-port meta, stable while that port's head beat is valid.
- o_req_ready  out  N_PORT  per-port beat accept; a beat transfers when valid&ready.
- i_alf  in  1  downstream almost-full.
- o_data_valid  out  1  output beat valid.
- o_data  out  134  output beat.
- o_meta_valid  out  1  pulses with the output head beat.
- o_meta  out  168  meta of the current packet.
- o_pkt_cnt  out  N_PORT*CNT_W  forwarded-packet count per port.
- o_err_cnt  out  CNT_W  dropped malformed-packet count (all ports).

Behaviour:
- Interface: one clock (i_sys_clk); reset is asynchronous and active-high (i_rst).
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0.
  - o_req_ready=0, o_data_valid=0, o_meta_valid=0.
  - o_data=0, o_meta=0, all counters=0.
- Reset mid-packet: the packet is truncated; no tail is synthesised.
- o_req_ready is combinational from state and grant only, never from i_req_valid: ready[grant]=1 in XFER and DROP; all other bits 0.
- IDLE:
  - Candidate set C = ports with valid=1 and tag!=01 (malformed); these take priority.
  - If C is empty, C = ports with valid=1 and tag==01, considered only when i_alf=0.
  - Winner = first port in C searching upward from rr_ptr, wrapping at N_PORT-1 -> 0.
  - Winner is latched into grant; next state is DROP if malformed, else XFER.
  - No beat is accepted in IDLE. Grant-to-head-accept latency is 1 cycle.
- XFER: beats from port grant are accepted whenever valid.
  - The accepted beat is registered to o_data with o_data_valid=1 one cycle later.
  - On the accepted head beat: o_meta<=meta[grant] and o_meta_valid=1 for that same output cycle.
  - Accepted tail: o_pkt_cnt[grant]++ (wraps), rr_ptr<=grant+1 mod N_PORT, next state IDLE.
  - A valid-low bubble from the granted port produces an output bubble (o_data_valid=0). Grant is held; there is no timeout.
  - A second head (tag 01) arriving mid-packet is forwarded as-is; the arbiter does not police it.
  - i_alf is ignored inside XFER; the downstream margin covers the remainder of the packet.
- DROP: beats from grant are accepted and discarded (o_data_valid=0).
  - On the tail: o_err_cnt++ (wraps), rr_ptr<=grant+1, next state IDLE.
- Minimum packet length is 2 beats (head..tail). Back-to-back packets from a single port therefore have at least 1 idle arbitration cycle between them.
- Simultaneous events:
  - i_alf rising in the same cycle as an IDLE grant decision blocks new head grants; i_alf is sampled combinationally.
  - DROP arbitration proceeds regardless of i_alf.
- Counters saturate? No: they wrap modulo 2^CNT_W.

Decomposition:
- Shared package pkt_pkg: tag constants TAG_HEAD=2'b01, TAG_BODY=2'b11, TAG_TAIL=2'b10; widths DATA_W=134, META_W=168; state encoding IDLE=0, XFER=1, DROP=2.
- One sub-module, rr_pick: combinational round-robin first-one search (inputs req vector and rr_ptr; outputs any and idx).

Test Plan:
- Single port 0 sends a 3-beat pkt (01,11,10) with meta=168'hA5: outputs 3 beats at +2..+4 cycles after valid, o_meta_valid with the head, o_meta=A5, o_pkt_cnt[0]=1, rr_ptr=1.
- All 4 ports continuously hold 2-beat pkts: grant order 0,1,2,3,0,...; no interleaving of beats between packets; every o_pkt_cnt=2 after 8 packets.
- i_alf=1 with port 2 head pending: no grant and no output; drop i_alf -> head out 2 cycles later; raising i_alf mid-packet does not stall the remaining beats.
- Port 1 front beat tag=11 (no head), 2 beats ending in tail: consumed with no output, o_err_cnt=1; port 3 head waiting concurrently is served next.
- Port 0 deasserts valid for 5 cycles mid-packet: output shows a 5-cycle bubble; port 1's pending head is not granted until port 0's tail is accepted.
- Assert i_rst during beat 2 of a 4-beat pkt: all outputs 0 immediately, counters 0; the next packet starts cleanly from rr_ptr=0.
